branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- ID-stage counterpart to the fetch-side BTB predictor.
- Carries each fetched instruction's prediction metadata (taken, target, 2-bit FSM state) through the IF/ID boundary and compares it against the actual branch/jump outcome computed in ID.
- Drives the fetch redirect and IF flush on a mispredict.
- Produces the registered, exactly-once BTB update transaction (update_en, branch_taken, resolved_pc, resolved_target, resolved_state) consumed by the predictor.

Parameters:
- XLEN, 32, PC/target width.
- INSTR_BYTES, 4, fall-through increment (pc + INSTR_BYTES).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_valid  in  1  IF slot holds a real instruction.
- if_pc  in  XLEN  PC of IF instruction.
- if_pred_taken  in  1  predictor's prediction_taken for if_pc.
- if_pred_target  in  XLEN  predictor's predicted_target.
- if_pred_state  in  2  predictor's FSM state for if_pc.
- stall_id  in  1  hold ID contents (hazard stall).
- flush_id  in  1  kill ID contents (redirect from a later stage).
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_is_jump  in  1  ID instruction is an unconditional jump (JAL/JALR).
- id_cond_true  in  1  branch comparison result in ID.
- id_target  in  XLEN  computed branch/jump target in ID.
- redirect_valid  out  1  fetch must load redirect_pc this cycle.
- redirect_pc  out  XLEN  correct next PC.
- flush_if  out  1  kill the instruction currently in IF.
- update_en  out  1  BTB write strobe, one-cycle pulse.
- branch_taken  out  1  actual outcome.
- resolved_pc  out  XLEN  PC of resolved instruction.
- resolved_target  out  XLEN  actual target.
- resolved_state  out  2  FSM state carried from fetch.

Behaviour:
- Metadata register (meta_valid, pc, pred_taken, pred_target, pred_state):
  - rst → all zero.
  - flush_id → meta_valid=0 (priority over stall).
  - else stall_id → hold.
  - else load from IF; meta_valid = if_valid & ~flush_if.
- Resolution, combinational in ID:
  - is_cf = meta_valid & (id_is_branch | id_is_jump) & ~done.
  - actual_taken = id_is_jump | (id_is_branch & id_cond_true).
  - actual_next = actual_taken ? id_target : pc + INSTR_BYTES, modulo 2^XLEN, so 0xFFFFFFFC wraps to 0.
  - mispredict = is_cf & ((pred_taken != actual_taken) | (actual_taken & pred_target != id_target)).
  - A non-control-flow instruction predicted taken (BTB alias) is also a mispredict: redirect to pc + INSTR_BYTES, no update.
- Redirect: redirect_valid = flush_if = mispredict, same cycle (zero latency); redirect_pc = actual_next, else 0. A predicted-taken branch that was taken to the same target produces no redirect.
- done flag: once-per-instruction guard.
  - Set when is_cf is resolved while stall_id=1.
  - Cleared on any new load into the metadata register or on flush_id.
  - Ensures a stalled branch resolves, redirects and updates exactly once.
- Update register, 1-cycle latency:
  - On the edge after is_cf: update_en=1 for exactly one cycle.
  - branch_taken=actual_taken, resolved_pc=pc, resolved_target=id_target, resolved_state=pred_state.
  - If is_cf is 0 on that edge, update_en returns to 0; data fields hold their last values.
- flush_id in the same cycle as is_cf: suppresses redirect and update (younger-than-flush instruction).
- Reset values: every output is 0.
- Reset mid-operation: a pending update and the done flag are discarded immediately (asynchronous).

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- With macro: adds ports stat_branches (out, 32) and stat_mispredicts (out, 32).
  - Saturating counters, reset 0.
  - Incremented on the same edge that raises update_en.
  - stat_mispredicts additionally requires that cycle's mispredict.
  - Both saturate at 0xFFFFFFFF.
- Without macro: ports and logic absent; all other behaviour identical.

Decomposition:
- Package branch_pkg:
  - state_t enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), moved out of the predictor so both blocks share it.
  - XLEN_DEFAULT constant.
  - Packed struct bp_meta_t {valid, pc, pred_taken, pred_target, pred_state}.
- Sub-module: sat_counter (WIDTH, en, count), instantiated twice under BRANCH_RESOLVER_STATS_EN.

Test Plan:
- Branch at pc=0x100 predicted not-taken, cond true, target 0x140:
  - Same cycle: redirect_valid=1, redirect_pc=0x140, flush_if=1.
  - Next cycle: update_en=1, branch_taken=1, resolved_pc=0x100, resolved_target=0x140, resolved_state=pred_state.
- Branch at 0x200 predicted taken to 0x180, cond true, id_target 0x180: no redirect; one update_en pulse with branch_taken=1.
- Same branch with id_target=0x1C0: redirect_pc=0x1C0, one update pulse.
- Branch at 0x300 held with stall_id=1 for 3 cycles, mispredicted:
  - redirect_valid high only in the first cycle.
  - Exactly one update_en pulse.
- flush_id asserted while a mispredicted branch sits in ID: no redirect, no update, meta_valid=0 next cycle.
- rst asserted during an update_en cycle: all outputs 0 immediately. With BRANCH_RESOLVER_STATS_EN, preload a counter to 0xFFFFFFFF and apply one more update: the count holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch-prediction types: the 2-bit predictor FSM state and the
// per-instruction prediction metadata carried from IF into ID.
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [XLEN_DEFAULT-1:0] pc;
    logic                    pred_taken;
    logic [XLEN_DEFAULT-1:0] pred_target;
    state_t                  pred_state;
  } bp_meta_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on en and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: checks fetch predictions, redirects fetch on a
// mispredict and emits one BTB update per branch. Optional statistics
// counters are enabled with `define BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_pred_taken,
  input  logic [XLEN-1:0] if_pred_target,
  input  logic [1:0]      if_pred_state,
  input  logic            stall_id,
  input  logic            flush_id,
  input  logic            id_is_branch,
  input  logic            id_is_jump,
  input  logic            id_cond_true,
  input  logic [XLEN-1:0] id_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if,
  output logic            update_en,
  output logic            branch_taken,
  output logic [XLEN-1:0] resolved_pc,
  output logic [XLEN-1:0] resolved_target,
  output logic [1:0]      resolved_state
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  // Metadata storage is sized by XLEN_DEFAULT, so XLEN must match it.
  bp_meta_t        meta_q, meta_d;
  logic            done_q, done_d;
  logic            upd_en_q, upd_en_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [XLEN-1:0] rtgt_q, rtgt_d;
  state_t          rstate_q, rstate_d;

  logic            is_cf, alias_hit, actual_taken, mispredict;
  logic [XLEN-1:0] fall_through, actual_next;

  // A predicted-taken non-branch is a BTB alias and must fall through.
  always_comb begin
    is_cf        = meta_q.valid & (id_is_branch | id_is_jump) & ~done_q;
    alias_hit    = meta_q.valid & ~(id_is_branch | id_is_jump) & meta_q.pred_taken & ~done_q;
    actual_taken = id_is_jump | (id_is_branch & id_cond_true);
    fall_through = meta_q.pc + XLEN'(INSTR_BYTES);
    actual_next  = actual_taken ? id_target : fall_through;
    mispredict   = ~flush_id & (alias_hit |
                   (is_cf & ((meta_q.pred_taken != actual_taken) |
                             (actual_taken & (meta_q.pred_target != id_target)))));
  end

  always_comb begin
    meta_d = meta_q;
    if (flush_id) begin
      meta_d.valid = 1'b0;
    end else if (!stall_id) begin
      meta_d.valid       = if_valid & ~mispredict;
      meta_d.pc          = if_pc;
      meta_d.pred_taken  = if_pred_taken;
      meta_d.pred_target = if_pred_target;
      meta_d.pred_state  = state_t'(if_pred_state);
    end
  end

  // done stops a stalled instruction from resolving again on later cycles.
  always_comb begin
    done_d = done_q;
    if (flush_id || !stall_id)  done_d = 1'b0;
    else if (is_cf || alias_hit) done_d = 1'b1;
  end

  always_comb begin
    upd_en_d = is_cf & ~flush_id;
    taken_d  = taken_q;
    rpc_d    = rpc_q;
    rtgt_d   = rtgt_q;
    rstate_d = rstate_q;
    if (upd_en_d) begin
      taken_d  = actual_taken;
      rpc_d    = meta_q.pc;
      rtgt_d   = id_target;
      rstate_d = meta_q.pred_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= '0;
      done_q   <= 1'b0;
      upd_en_q <= 1'b0;
      taken_q  <= 1'b0;
      rpc_q    <= '0;
      rtgt_q   <= '0;
      rstate_q <= STRONG_NT;
    end else begin
      meta_q   <= meta_d;
      done_q   <= done_d;
      upd_en_q <= upd_en_d;
      taken_q  <= taken_d;
      rpc_q    <= rpc_d;
      rtgt_q   <= rtgt_d;
      rstate_q <= rstate_d;
    end
  end

  assign redirect_valid  = mispredict;
  assign flush_if        = mispredict;
  assign redirect_pc     = mispredict ? actual_next : '0;
  assign update_en       = upd_en_q;
  assign branch_taken    = taken_q;
  assign resolved_pc     = rpc_q;
  assign resolved_target = rtgt_q;
  assign resolved_state  = rstate_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  sat_counter #(.WIDTH(32)) u_stat_branches (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_en_d),
    .count (stat_branches)
  );

  sat_counter #(.WIDTH(32)) u_stat_mispredicts (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_en_d & mispredict),
    .count (stat_mispredicts)
  );
`endif

endmodule
